rr_mux_arbiter: RTL
===================

# rr_mux_arbiter

Round-robin arbiter that shares one 4:1 multiplexer datapath among four requesters. It registers a one-hot grant and a 2-bit select. The select steers the selected requester's data onto a single output bus. An optional hold-limit timer stops any single requester from monopolising the mux. The block sits between the lab's requester logic and the shared 4:1 mux datapath, which it instantiates internally.

## Interface
- WIDTH, default 1: data width of each mux input and of the output.
- MAX_HOLD, default 8: maximum consecutive grant cycles before a forced handoff. Range 1..255. Used only when RR_ARB_TIMEOUT_EN is defined.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request per requester, level-sensitive; bit i is requester i.
- d0, d1, d2, d3  input  WIDTH each  requester data inputs.
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered mux select, equal to the index of the granted requester.
- valid  output  1  registered; high while any grant is held.
- y  output  WIDTH  selected data: d[sel] when valid is high, all zero otherwise. Purely combinational from registered sel/valid.

## Operation
- Reset values: state=IDLE, gnt=0000, sel=00, valid=0, ptr=00, cnt=0, y=0.
- ptr is the round-robin priority pointer. The search order is ptr, ptr+1, ptr+2, ptr+3, all modulo 4. The first requester in that order with req high wins.
- States: IDLE and GRANT.
- IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise pick winner w by the search order. Next cycle: state=GRANT, gnt=1<<w, sel=w, valid=1, ptr=(w+1) mod 4, cnt=0.
- GRANT, owner o=sel:
  - **Release:** req[o]==0. Run the search over req with bit o masked.
    - If a winner w exists, go directly GRANT→GRANT to w, with no idle cycle. Update ptr=(w+1) mod 4 and set cnt=0.
    - If no winner, go to IDLE: gnt=0000, valid=0. sel holds its last value.
  - **Hold:** req[o]==1 and no forced handoff. Stay in GRANT with the same owner; cnt increments, saturating at MAX_HOLD.
  - **Forced handoff** (RR_ARB_TIMEOUT_EN only): cnt==MAX_HOLD-1 and at least one other req bit high. The masked search picks w and the grant moves exactly as in Release.
  - If cnt reaches MAX_HOLD-1 and no other request is pending, the owner keeps the grant and cnt resets to 0.
- Simultaneous events: release and a new request arriving in the same cycle resolve in a single arbitration. ptr wraps modulo 4; for example, a winner at index 3 sets ptr=0.
- Grant is never given to a requester whose req is low in the arbitration cycle.
- Reset asserted mid-grant forces all reset values immediately, asynchronously. y goes to 0 in the same cycle.

## Timing
- Latency from req to gnt/valid/sel is 1 cycle: req sampled at edge n gives a grant visible after edge n.
- Release: req[o] low at edge n moves gnt (or clears it) after edge n.
- y follows sel/valid combinationally. There is no added pipeline stage from data input to y.
- With RR_ARB_TIMEOUT_EN and a contending requester, an owner holds the grant for exactly MAX_HOLD cycles.
- Counter width: $clog2(MAX_HOLD+1) bits.

## Configuration
- RR_ARB_TIMEOUT_EN defined: cnt and the forced-handoff logic are compiled in, and the MAX_HOLD rule applies.
- RR_ARB_TIMEOUT_EN undefined: cnt is removed. The owner keeps the grant until its req drops, and MAX_HOLD is ignored. All other behaviour is identical.

## Structure
- Shared package rr_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the constant N_REQ=4;
  - the function rr_pick(req, ptr, mask), which returns the winner index and a found flag.
- One sub-module, rr_mux4w: a WIDTH-bit 4:1 mux (d0..d3, sel → y_raw). The top level gates y_raw with valid.

## Test plan
- **Reset, idle and simple grant:** hold reset high, then release it with req=0000 → gnt=0000, valid=0, y=0. Then apply req=0100, d2=1 → one cycle later gnt=0100, sel=2, valid=1, y=1, ptr=3.
- **Round-robin wrap:** with ptr=3 and req=1001 → grant to 3. Drop req[3] → next cycle grant moves to 0 with no idle cycle.
- **Simultaneous requests:** after reset apply req=1111 and drop each owner's req after 1 cycle → grant sequence 0,1,2,3, with each owner granted for 1 cycle.
- **Hold limit:** RR_ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=0011 held constant → grant alternates 0,1,0,1 with each owner granted for 4 cycles. Rerun with the macro undefined → requester 0 holds the grant indefinitely.
- **Lone owner at limit:** RR_ARB_TIMEOUT_EN defined, req=0010 only → grant stays on 1 past MAX_HOLD cycles, with cnt wrapping to 0.
- **Mid-grant reset:** assert reset asynchronously between edges while gnt=1000 → gnt=0000, valid=0, y=0 before the next edge. After release, req=1000 → grant to 3 after one edge.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and the round-robin search helper for rr_mux_arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Search ptr, ptr+1, ... (mod 4); masked bits are never picked.
  // Walking the order backwards lets the earliest candidate overwrite later ones.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [1:0]       ptr,
                                    input logic [N_REQ-1:0] mask);
    pick_t            p;
    logic [N_REQ-1:0] r;
    logic [1:0]       k;
    p = '0;
    r = req & ~mask;
    for (int i = N_REQ-1; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (r[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_mux4w.sv
// WIDTH-bit 4:1 mux shared by the four requesters.
module rr_mux4w
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y_raw
);

  logic [N_REQ-1:0][WIDTH-1:0] dv;

  assign dv    = {d3, d2, d1, d0};
  assign y_raw = dv[sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux; registered one-hot grant and select.
// Optional hold-limit timer compiled in with RR_ARB_TIMEOUT_EN.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] y
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_mux_arbiter: MAX_HOLD out of range 1..255");
  end

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] own_mask;
  pick_t      pick_idle, pick_rel;
  logic       rel, forced, handoff;
  logic [WIDTH-1:0] y_raw;

  assign own_mask  = 4'b0001 << sel;
  assign pick_idle = rr_pick(req, ptr, 4'b0000);
  assign pick_rel  = rr_pick(req, ptr, own_mask);
  assign rel       = ~req[sel];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);
  logic [CW-1:0] cnt;

  assign forced = (cnt == LAST) && |(req & ~own_mask);
`else
  assign forced = 1'b0;
`endif

  assign handoff = rel | forced;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      valid <= 1'b0;
      ptr   <= 2'd0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle.found) begin
            state <= GRANT;
            gnt   <= 4'b0001 << pick_idle.idx;
            sel   <= pick_idle.idx;
            valid <= 1'b1;
            ptr   <= pick_idle.idx + 2'd1;
`ifdef RR_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        GRANT: begin
          if (handoff) begin
            // Release and forced handoff share one masked search; no idle bubble.
            if (pick_rel.found) begin
              gnt   <= 4'b0001 << pick_rel.idx;
              sel   <= pick_rel.idx;
              ptr   <= pick_rel.idx + 2'd1;
`ifdef RR_ARB_TIMEOUT_EN
              cnt   <= '0;
`endif
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
              valid <= 1'b0;
            end
          end else begin
`ifdef RR_ARB_TIMEOUT_EN
            // A lone owner at the limit keeps the grant and restarts its window.
            if (cnt == LAST)
              cnt <= '0;
            else if (cnt != CW'(MAX_HOLD))
              cnt <= cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rr_mux4w #(.WIDTH(WIDTH)) u_mux (
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .sel   (sel),
    .y_raw (y_raw)
  );

  assign y = valid ? y_raw : '0;

endmodule
